// File: rtl/seq_alu_if.sv
// Operand/result bus between the register file and the sequential ALU.
// The master drives the operation request; the slave (ALU) returns the write.
interface seq_alu_if;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] SELECT;
  logic [2:0] DEST;
  logic       START;
  logic [7:0] RESULT;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSY;
  logic       DONE;

  modport master (
    output DATA1, DATA2, SELECT, DEST, START,
    input  RESULT, INADDRESS, WRITE, BUSY, DONE
  );

  modport slave (
    input  DATA1, DATA2, SELECT, DEST, START,
    output RESULT, INADDRESS, WRITE, BUSY, DONE
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle 8-bit ALU: single-step logic/add, 8-step shift-add multiply,
// and bit-per-step shifts; result written back through a one-cycle strobe.
module seq_alu (
  input logic     CLK,
  input logic     RESET,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, b_q, acc_q;
  logic [7:0] a_d, b_d, acc_d, res_d;
  logic [2:0] sel_q, dest_q;
  logic [3:0] cnt_q, cnt_ld;
  logic       shz_q;
  logic [7:0] result_q;
  logic [2:0] inaddr_q;

  // Step count for the request on the bus; zero shift still costs one step.
  always_comb begin
    cnt_ld = 4'd1;
    unique case (bus.SELECT)
      3'b100: cnt_ld = 4'd8;
      3'b101,
      3'b110,
      3'b111: begin
        if (bus.DATA2[2:0] == 3'd0) cnt_ld = 4'd1;
        else cnt_ld = {1'b0, bus.DATA2[2:0]};
      end
      default: cnt_ld = 4'd1;
    endcase
  end

  // One EXEC step on the captured operands.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    res_d = 8'h00;
    unique case (sel_q)
      3'b000: res_d = b_q;
      3'b001: res_d = a_q + b_q;
      3'b010: res_d = a_q & b_q;
      3'b011: res_d = a_q | b_q;
      3'b100: begin
        acc_d = acc_q + (b_q[0] ? a_q : 8'h00);
        a_d   = {a_q[6:0], 1'b0};
        b_d   = {1'b0, b_q[7:1]};
        res_d = acc_d;
      end
      3'b101: begin
        a_d   = shz_q ? a_q : {a_q[6:0], 1'b0};
        res_d = a_d;
      end
      3'b110: begin
        a_d   = shz_q ? a_q : {1'b0, a_q[7:1]};
        res_d = a_d;
      end
      3'b111: begin
        a_d   = shz_q ? a_q : {a_q[0], a_q[7:1]};
        res_d = a_d;
      end
    endcase
  end

  // Next-state logic; START outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.START) state_d = EXEC;
      EXEC: if (cnt_q == 4'd1) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Operand capture, per-step update and result write-back.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      acc_q    <= 8'h00;
      sel_q    <= 3'd0;
      dest_q   <= 3'd0;
      cnt_q    <= 4'd0;
      shz_q    <= 1'b0;
      result_q <= 8'h00;
      inaddr_q <= 3'd0;
    end else if (state_q == IDLE && bus.START) begin
      a_q    <= bus.DATA1;
      b_q    <= bus.DATA2;
      acc_q  <= 8'h00;
      sel_q  <= bus.SELECT;
      dest_q <= bus.DEST;
      cnt_q  <= cnt_ld;
      shz_q  <= (bus.DATA2[2:0] == 3'd0);
    end else if (state_q == EXEC) begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        result_q <= res_d;
        inaddr_q <= dest_q;
      end
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.INADDRESS = inaddr_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = (state_q == FIN);
  assign bus.WRITE     = (state_q == FIN);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: reset, each opcode class, busy-time START
// and mid-operation reset, with hand-computed expectations.
module tb_seq_alu;

  logic CLK;
  logic RESET;
  int   n_tests;
  int   n_fail;

  seq_alu_if bus ();

  seq_alu dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op, scramble inputs after capture, wait for DONE.
  task automatic op(input string tag, input logic [7:0] a,
                    input logic [7:0] b, input logic [2:0] sel,
                    input logic [2:0] d, input int exp_res,
                    input int exp_lat);
    int lat;
    int busy_n;
    bus.DATA1  = a;
    bus.DATA2  = b;
    bus.SELECT = sel;
    bus.DEST   = d;
    bus.START  = 1'b1;
    tick();
    bus.START  = 1'b0;
    bus.DATA1  = ~a;
    bus.DATA2  = ~b;
    bus.SELECT = ~sel;
    bus.DEST   = ~d;
    lat    = 0;
    busy_n = 0;
    while (!bus.DONE && lat < 20) begin
      busy_n += int'(bus.BUSY);
      tick();
      lat++;
    end
    busy_n += int'(bus.BUSY);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, int'(bus.RESULT), exp_res);
    check({tag, "_addr"}, int'(bus.INADDRESS), int'(d));
    check({tag, "_wr"}, int'(bus.WRITE), 1);
    check({tag, "_busy"}, busy_n, exp_lat + 1);
    tick();
    check({tag, "_done0"}, int'(bus.DONE), 0);
    check({tag, "_idle"}, int'(bus.BUSY), 0);
    check({tag, "_hold"}, int'(bus.RESULT), exp_res);
  endtask

  initial begin
    int done_n;
    int k;
    n_tests = 0;
    n_fail  = 0;
    RESET      = 1'b0;
    bus.START  = 1'b1;
    bus.DATA1  = 8'h55;
    bus.DATA2  = 8'h33;
    bus.SELECT = 3'b001;
    bus.DEST   = 3'd6;
    tick();
    tick();
    check("rst_res", int'(bus.RESULT), 0);
    check("rst_addr", int'(bus.INADDRESS), 0);
    check("rst_wr", int'(bus.WRITE), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_done", int'(bus.DONE), 0);
    RESET     = 1'b1;
    bus.START = 1'b0;

    op("add", 8'd200, 8'd100, 3'b001, 3'd3, 8'h2C, 1);
    op("mul1", 8'd13, 8'd11, 3'b100, 3'd5, 8'h8F, 8);
    op("mul2", 8'd20, 8'd20, 3'b100, 3'd2, 8'h90, 8);
    op("sll", 8'h81, 8'd3, 3'b101, 3'd1, 8'h08, 3);
    op("ror", 8'h81, 8'd1, 3'b111, 3'd7, 8'hC0, 1);
    op("srl0", 8'h81, 8'd0, 3'b110, 3'd4, 8'h81, 1);
    op("srl5", 8'hF0, 8'd5, 3'b110, 3'd4, 8'h07, 5);
    op("and", 8'hF0, 8'h3C, 3'b010, 3'd1, 8'h30, 1);
    op("or", 8'hF0, 8'h3C, 3'b011, 3'd2, 8'hFC, 1);
    op("fwd", 8'h12, 8'h5A, 3'b000, 3'd6, 8'h5A, 1);
    op("add_wrap", 8'hFF, 8'h01, 3'b001, 3'd0, 8'h00, 1);

    bus.DATA1  = 8'd5;
    bus.DATA2  = 8'd6;
    bus.SELECT = 3'b100;
    bus.DEST   = 3'd2;
    bus.START  = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    bus.DATA1  = 8'd1;
    bus.DATA2  = 8'd1;
    bus.SELECT = 3'b001;
    bus.DEST   = 3'd1;
    bus.START  = 1'b1;
    tick();
    bus.START = 1'b0;
    done_n = 0;
    k      = 3;
    while (!bus.DONE && k < 20) begin
      tick();
      k++;
    end
    check("bsy_lat", k, 8);
    check("bsy_res", int'(bus.RESULT), 30);
    check("bsy_addr", int'(bus.INADDRESS), 2);
    for (int i = 0; i < 6; i++) begin
      done_n += int'(bus.DONE);
      tick();
    end
    check("bsy_ndone", done_n, 1);
    op("after", 8'd1, 8'd1, 3'b001, 3'd1, 2, 1);

    bus.DATA1  = 8'd9;
    bus.DATA2  = 8'd9;
    bus.SELECT = 3'b100;
    bus.DEST   = 3'd4;
    bus.START  = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("mrst_busy", int'(bus.BUSY), 0);
    check("mrst_res", int'(bus.RESULT), 0);
    check("mrst_addr", int'(bus.INADDRESS), 0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      done_n += int'(bus.DONE) + int'(bus.WRITE);
      tick();
    end
    check("mrst_nowr", done_n, 0);

    op("post_rst", 8'd7, 8'd3, 3'b100, 3'd3, 21, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
